// File: rtl/cpu_port_capture_pkg.sv
// Shared definitions for the cpu output ports and their event consumers.
// An event is packed as {port index, data}: port index in the MSBs, captured
// value in the low WIDTH bits, so the cpu side and every sink agree on it.
package cpu_port_capture_pkg;

  localparam int NUM_PORTS     = 4;
  localparam int PORT_IDX_W    = 2;
  localparam int DEFAULT_WIDTH = 16;

  // Result of a fixed-priority pick: whether any request was set, and which.
  typedef struct packed {
    logic                  found;
    logic [PORT_IDX_W-1:0] idx;
  } arb_t;

  // Fixed priority, lowest index wins (p0 > p1 > p2 > p3).
  function automatic arb_t prio_pick(input logic [NUM_PORTS-1:0] req);
    arb_t r;
    r.found = 1'b0;
    r.idx   = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (req[i]) begin
        r.found = 1'b1;
        r.idx   = PORT_IDX_W'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/cpu_port_capture_sync_fifo.sv
// Synchronous show-ahead FIFO with a registered head and an occupancy count.
// The head register holds its last value when the FIFO drains empty.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module cpu_port_capture_sync_fifo #(
  parameter int DW    = 18,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [DW-1:0]            push_data,
  input  logic                     pop,
  output logic                     valid,
  output logic [DW-1:0]            head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [DW-1:0] head_q, head_d;
  logic          do_push, do_pop;

  // Next pointers, occupancy and the head entry that will be visible after this edge.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    head_d  = head_q;
    count_d = count_q;
    do_pop  = pop && (count_q != '0);
    do_push = push && ((count_q != FULL_CNT) || do_pop);

    // Pointers are exactly AW bits wide, so wrap modulo DEPTH is free.
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);

    if (do_push && !do_pop) begin
      count_d = count_q + CW'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - CW'(1);
    end

    // The new head is the word being written when it lands at the new read pointer
    // (empty FIFO, or last entry popped while a push arrives); otherwise memory.
    if (count_d != '0) begin
      head_d = (do_push && (wr_ptr_q == rd_ptr_d)) ? push_data : mem[rd_ptr_d];
    end
  end

  // Control state and head register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking (<=) so all flops update from pre-edge values.
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is not reset; count_q==0 already marks every entry invalid.
    if (do_push) begin
      mem[wr_ptr_q] <= push_data;
    end
  end

  assign valid = (count_q != '0);
  assign head  = head_q;
  assign count = count_q;

endmodule

// File: rtl/cpu_port_capture.sv
// Captures every value change on cpu ports p0..p3 as {port, value} events.
// Each port has a shadow copy (change detector), a hold register (value
// waiting to be queued) and a pending flag. A fixed-priority arbiter moves one
// pending value per cycle into the event FIFO, which drains over valid/ready.
module cpu_port_capture
  import cpu_port_capture_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [WIDTH-1:0]        p0,
  input  logic [WIDTH-1:0]        p1,
  input  logic [WIDTH-1:0]        p2,
  input  logic [WIDTH-1:0]        p3,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [PORT_IDX_W-1:0]   out_port,
  output logic [WIDTH-1:0]        out_data,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic [CNT_W-1:0]        overrun_cnt
);

  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int EVT_W = PORT_IDX_W + WIDTH;
  localparam int SUM_W = CNT_W + 3;
  localparam logic [CW-1:0]    FULL_CNT = CW'(DEPTH);
  localparam logic [SUM_W-1:0] CNT_MAX  = {3'b000, {CNT_W{1'b1}}};

  logic [WIDTH-1:0]     p_arr    [NUM_PORTS];
  logic [WIDTH-1:0]     shadow_q [NUM_PORTS];
  logic [WIDTH-1:0]     shadow_d [NUM_PORTS];
  logic [WIDTH-1:0]     hold_q   [NUM_PORTS];
  logic [WIDTH-1:0]     hold_d   [NUM_PORTS];
  logic [NUM_PORTS-1:0] pend_q, pend_d;
  logic [NUM_PORTS-1:0] change, pushed;
  logic [2:0]           n_over;
  logic [SUM_W-1:0]     ovr_sum;
  logic [CNT_W-1:0]     overrun_cnt_q, overrun_cnt_d;

  arb_t             pick;
  logic             pop, push_ok, push;
  logic [EVT_W-1:0] push_evt, head_evt;

  assign p_arr[0] = p0;
  assign p_arr[1] = p1;
  assign p_arr[2] = p2;
  assign p_arr[3] = p3;

  // Arbiter: pick the highest-priority pending port and push it if the FIFO has room.
  always_comb begin
    pop      = out_valid && out_ready;
    push_ok  = (fifo_count != FULL_CNT) || pop;
    pick     = prio_pick(pend_q);
    push     = pick.found && push_ok;
    push_evt = {pick.idx, hold_q[pick.idx]};
  end

  // Change detection, pending/hold update and overrun accounting.
  always_comb begin
    change = '0;
    pushed = '0;
    n_over = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      change[i]   = (p_arr[i] != shadow_q[i]);
      pushed[i]   = push && (pick.idx == PORT_IDX_W'(i));
      // Shadow always tracks the sampled port, so a change updates it and no change is a no-op.
      shadow_d[i] = p_arr[i];
      hold_d[i]   = change[i] ? p_arr[i] : hold_q[i];
      // A change on the same edge as the push re-arms the flag with the new value.
      pend_d[i]   = change[i] | (pend_q[i] & ~pushed[i]);
      // Overwriting a value that is still waiting (and not leaving this edge) loses it.
      if (change[i] && pend_q[i] && !pushed[i]) begin
        n_over = n_over + 3'd1;
      end
    end
    ovr_sum       = SUM_W'(overrun_cnt_q) + SUM_W'(n_over);
    overrun_cnt_d = (ovr_sum > CNT_MAX) ? {CNT_W{1'b1}} : ovr_sum[CNT_W-1:0];
  end

  // Per-port capture registers and the saturating overrun counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        shadow_q[i] <= '0;
        hold_q[i]   <= '0;
      end
      pend_q        <= '0;
      overrun_cnt_q <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        shadow_q[i] <= shadow_d[i];
        hold_q[i]   <= hold_d[i];
      end
      pend_q        <= pend_d;
      overrun_cnt_q <= overrun_cnt_d;
    end
  end

  cpu_port_capture_sync_fifo #(
    .DW    (EVT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .push      (push),
    .push_data (push_evt),
    .pop       (pop),
    .valid     (out_valid),
    .head      (head_evt),
    .count     (fifo_count)
  );

  assign {out_port, out_data} = head_evt;
  assign overrun_cnt          = overrun_cnt_q;

endmodule

// File: tb/tb_cpu_port_capture.sv
// Self-checking bench for cpu_port_capture: a queue-based event model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_cpu_port_capture;

  localparam int WIDTH = 16;
  localparam int DEPTH = 8;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] p0, p1, p2, p3;
  logic             out_valid, out_ready;
  logic [1:0]       out_port;
  logic [WIDTH-1:0] out_data;
  logic [3:0]       fifo_count;
  logic [CNT_W-1:0] overrun_cnt;

  int n_cmp = 0;
  int n_err = 0;

  cpu_port_capture #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .p0          (p0),
    .p1          (p1),
    .p2          (p2),
    .p3          (p3),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_port    (out_port),
    .out_data    (out_data),
    .fifo_count  (fifo_count),
    .overrun_cnt (overrun_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each port: last seen value, one waiting value slot, and a waiting flag.
  // Events live in a plain queue; the head shown to the sink is its front.
  logic [WIDTH-1:0] m_last [4];
  logic [WIDTH-1:0] m_wait [4];
  bit               m_has  [4];
  logic [17:0]      m_q [$];
  logic [17:0]      m_head = '0;
  int               m_over = 0;
  logic [WIDTH-1:0] m_pv [4];
  bit               m_pop, m_room;
  int               m_sel;
  logic [17:0]      m_ev;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        m_last[i] = '0;
        m_wait[i] = '0;
        m_has[i]  = 1'b0;
      end
      m_q.delete();
      m_head = '0;
      m_over = 0;
    end else begin
      m_pv   = '{p0, p1, p2, p3};
      m_pop  = (m_q.size() != 0) && out_ready;
      m_room = (m_q.size() < DEPTH) || m_pop;
      m_sel  = -1;
      for (int i = 3; i >= 0; i--) if (m_has[i]) m_sel = i;
      if (m_sel >= 0 && m_room) begin
        m_ev = {2'(m_sel), m_wait[m_sel]};
        m_has[m_sel] = 1'b0;   // taken this edge, so a new value just re-arms
      end else begin
        m_sel = -1;
      end
      for (int i = 0; i < 4; i++) begin
        if (m_pv[i] != m_last[i]) begin
          if (m_has[i]) m_over = (m_over < 255) ? m_over + 1 : 255;
          m_last[i] = m_pv[i];
          m_wait[i] = m_pv[i];
          m_has[i]  = 1'b1;
        end
      end
      if (m_pop) void'(m_q.pop_front());
      if (m_sel >= 0) m_q.push_back(m_ev);
      if (m_q.size() != 0) m_head = m_q[0];
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("cyc_count",   32'(fifo_count),  32'(m_q.size()));
    check("cyc_valid",   32'(out_valid),   32'(m_q.size() != 0));
    check("cyc_port",    32'(out_port),    32'(m_head[17:16]));
    check("cyc_data",    32'(out_data),    32'(m_head[15:0]));
    check("cyc_overrun", 32'(overrun_cnt), 32'(m_over));
  end

  // Record every event the sink accepts (ready only changes just after posedge).
  logic [17:0] seen [$];
  logic [17:0] exp_q [$];

  always @(negedge clk) begin
    if (reset && out_valid && out_ready) seen.push_back({out_port, out_data});
  end

  task automatic check_seen(input string tag);
    check({tag, "_nevents"}, 32'(seen.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < seen.size(); i++) begin
      check($sformatf("%s_ev%0d", tag, i), 32'(seen[i]), 32'(exp_q[i]));
    end
  endtask

  task automatic drive_slot();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    p0 = '0; p1 = '0; p2 = '0; p3 = '0;
    out_ready = 1'b0;

    // 1: reset with ports at zero
    #8;
    check("rst_valid",   32'(out_valid),   32'd0);
    check("rst_count",   32'(fifo_count),  32'd0);
    check("rst_overrun", 32'(overrun_cnt), 32'd0);
    check("rst_data",    32'(out_data),    32'd0);
    #2 reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("idle_valid", 32'(out_valid), 32'd0);
    end

    // 2: single change on p1, visible two edges after sampling, for one cycle
    drive_slot();
    p1 = 16'h00A5;
    out_ready = 1'b1;
    @(negedge clk); check("t2_pre_sample", 32'(out_valid), 32'd0);
    @(negedge clk); check("t2_after_k",    32'(out_valid), 32'd0);
    @(negedge clk);
    check("t2_valid", 32'(out_valid), 32'd1);
    check("t2_port",  32'(out_port),  32'd1);
    check("t2_data",  32'(out_data),  32'h00A5);
    @(negedge clk);
    check("t2_gone",      32'(out_valid), 32'd0);
    check("t2_held_data", 32'(out_data),  32'h00A5);
    check("t2_held_port", 32'(out_port),  32'd1);

    // 3: three ports change together -> priority order, consecutive cycles
    drive_slot();
    p0 = 16'd1; p2 = 16'd2; p3 = 16'd3;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("t3_ev0", 32'({out_valid, out_port, out_data}), 32'({1'b1, 2'd0, 16'd1}));
    @(negedge clk);
    check("t3_ev1", 32'({out_valid, out_port, out_data}), 32'({1'b1, 2'd2, 16'd2}));
    @(negedge clk);
    check("t3_ev2", 32'({out_valid, out_port, out_data}), 32'({1'b1, 2'd3, 16'd3}));
    @(negedge clk);
    check("t3_empty",   32'(out_valid),   32'd0);
    check("t3_overrun", 32'(overrun_cnt), 32'd0);

    // 4: fill with sink stalled, then one overwrite while full
    seen.delete();
    for (int k = 0; k < 9; k++) begin
      drive_slot();
      out_ready = 1'b0;
      p0 = 16'h1000 + 16'(k);
    end
    drive_slot();
    check("t4_full_count",  32'(fifo_count),  32'd8);
    check("t4_full_valid",  32'(out_valid),   32'd1);
    check("t4_no_overrun",  32'(overrun_cnt), 32'd0);
    p0 = 16'h1009;
    drive_slot();
    check("t4_overrun",     32'(overrun_cnt), 32'd1);
    check("t4_still_full",  32'(fifo_count),  32'd8);
    out_ready = 1'b1;
    drive_slot();
    check("t4_pushpop_cnt", 32'(fifo_count),  32'd8);
    drive_slot();
    check("t4_draining",    32'(fifo_count),  32'd7);
    repeat (14) @(negedge clk);
    exp_q.delete();
    for (int k = 0; k < 8; k++) exp_q.push_back({2'd0, 16'h1000 + 16'(k)});
    exp_q.push_back({2'd0, 16'h1009});
    check_seen("t4");

    // 5: full FIFO, sink ready and a steady stream of pending values
    seen.delete();
    for (int k = 0; k < 13; k++) begin
      drive_slot();
      if (k == 0) out_ready = 1'b0;
      if (k == 9) out_ready = 1'b1;
      p2 = 16'h2000 + 16'(k);
      if (k >= 10) check($sformatf("t5_steady%0d", k), 32'(fifo_count), 32'd8);
    end
    drive_slot(); check("t5_steady13", 32'(fifo_count), 32'd8);
    drive_slot(); check("t5_steady14", 32'(fifo_count), 32'd8);
    drive_slot(); check("t5_drain",    32'(fifo_count), 32'd7);
    repeat (12) @(negedge clk);
    exp_q.delete();
    for (int k = 0; k < 13; k++) exp_q.push_back({2'd2, 16'h2000 + 16'(k)});
    check_seen("t5");
    check("t5_overrun", 32'(overrun_cnt), 32'd1);

    // 6: reset with five queued and two pending events
    drive_slot(); out_ready = 1'b0; p0 = 16'h4001;
    drive_slot(); p0 = 16'h4002;
    drive_slot(); p0 = 16'h4003;
    drive_slot(); p1 = 16'h0000;
    drive_slot(); p2 = 16'h4200;
    drive_slot(); p0 = 16'h4004; p3 = 16'h4300;
    drive_slot();
    check("t6_queued", 32'(fifo_count), 32'd5);
    reset = 1'b0;
    #1;
    check("t6_rst_valid",   32'(out_valid),   32'd0);
    check("t6_rst_count",   32'(fifo_count),  32'd0);
    check("t6_rst_overrun", 32'(overrun_cnt), 32'd0);
    drive_slot();
    out_ready = 1'b1;
    drive_slot();
    reset = 1'b1;
    seen.delete();
    repeat (10) @(negedge clk);
    exp_q.delete();
    exp_q.push_back({2'd0, 16'h4004});
    exp_q.push_back({2'd2, 16'h4200});
    exp_q.push_back({2'd3, 16'h4300});
    check_seen("t6");
    check("t6_final_empty", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
